// File: rtl/core_seq.sv
// Multi-cycle accumulator core running a 6502 subset: FETCH / DECODE / EXEC / HALT.
// The core uses A, X and Y registers, N/V/Z/C flags, a zero-page store, an RDY stall and STP.
module core_seq #(
   parameter int unsigned   DW       = 8,
   parameter int unsigned   AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          RDY,
   output logic          RW,
   output logic [AW-1:0] AD,
   input  logic [DW-1:0] D_in,
   output logic [DW-1:0] D_out,
   output logic          SYNC,
   output logic          HALTED,
   output logic [3:0]    FLAGS
);

   typedef enum logic [3:0] {
      StFetch  = 4'b0001,
      StDecode = 4'b0010,
      StExec   = 4'b0100,
      StHalt   = 4'b1000
   } state_e;

   state_e        r_state, w_state_n;
   logic [AW-1:0] r_pc, w_pc_n;
   logic [DW-1:0] r_a, r_x, r_y, w_a_n, w_x_n, w_y_n;
   logic [7:0]    r_ir;
   logic          r_n, r_v, r_z, r_c;
   logic          w_n_n, w_v_n, w_z_n, w_c_n;

   logic [7:0]    w_op;
   logic          w_is_imm, w_sub, w_cin, w_ovf, w_set_nz, w_sta_exec;
   logic [DW-1:0] w_op2, w_res, w_nz_val;
   logic [DW:0]   w_sum;

   // Implied ops commit in DECODE, before IR holds the opcode.
   assign w_op = (r_state == StDecode) ? D_in[7:0] : r_ir;

   always_comb begin
      w_is_imm = 1'b0;
      case (w_op)
         8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9,
         8'h29, 8'h09, 8'h49, 8'hC9, 8'h85: w_is_imm = 1'b1;
         default:                           w_is_imm = 1'b0;
      endcase
   end

   assign w_sub   = (w_op == 8'hE9) || (w_op == 8'hC9);
   assign w_op2   = w_sub ? ~D_in : D_in;
   assign w_cin   = (w_op == 8'hC9) ? 1'b1 : r_c;
   assign w_sum   = {1'b0, r_a} + {1'b0, w_op2} + {{DW{1'b0}}, w_cin};
   assign w_res   = w_sum[DW-1:0];
   assign w_ovf   = (r_a[DW-1] == w_op2[DW-1]) && (w_res[DW-1] != r_a[DW-1]);

   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_a_n     = r_a;
      w_x_n     = r_x;
      w_y_n     = r_y;
      w_v_n     = r_v;
      w_c_n     = r_c;
      w_set_nz  = 1'b0;
      w_nz_val  = '0;
      unique case (r_state)
         StFetch: begin
            w_pc_n    = r_pc + 1'b1;
            w_state_n = StDecode;
         end
         StDecode: begin
            if (w_op == 8'hDB) begin
               w_state_n = StHalt;
            end else if (w_is_imm) begin
               w_pc_n    = r_pc + 1'b1;
               w_state_n = StExec;
            end else begin
               w_state_n = StFetch;
               w_set_nz  = 1'b1;
               case (w_op)
                  8'hAA: begin w_x_n = r_a;        w_nz_val = r_a;        end
                  8'h8A: begin w_a_n = r_x;        w_nz_val = r_x;        end
                  8'hA8: begin w_y_n = r_a;        w_nz_val = r_a;        end
                  8'h98: begin w_a_n = r_y;        w_nz_val = r_y;        end
                  8'hE8: begin w_x_n = r_x + 1'b1; w_nz_val = r_x + 1'b1; end
                  8'hC8: begin w_y_n = r_y + 1'b1; w_nz_val = r_y + 1'b1; end
                  8'hCA: begin w_x_n = r_x - 1'b1; w_nz_val = r_x - 1'b1; end
                  8'h88: begin w_y_n = r_y - 1'b1; w_nz_val = r_y - 1'b1; end
                  8'h18: begin w_c_n = 1'b0;       w_set_nz = 1'b0;       end
                  8'h38: begin w_c_n = 1'b1;       w_set_nz = 1'b0;       end
                  default: w_set_nz = 1'b0;
               endcase
            end
         end
         StExec: begin
            w_state_n = StFetch;
            w_set_nz  = 1'b1;
            case (w_op)
               8'hA9: begin w_a_n = D_in;        w_nz_val = D_in;        end
               8'hA2: begin w_x_n = D_in;        w_nz_val = D_in;        end
               8'hA0: begin w_y_n = D_in;        w_nz_val = D_in;        end
               8'h29: begin w_a_n = r_a & D_in;  w_nz_val = r_a & D_in;  end
               8'h09: begin w_a_n = r_a | D_in;  w_nz_val = r_a | D_in;  end
               8'h49: begin w_a_n = r_a ^ D_in;  w_nz_val = r_a ^ D_in;  end
               8'h69, 8'hE9: begin
                  w_a_n    = w_res;
                  w_c_n    = w_sum[DW];
                  w_v_n    = w_ovf;
                  w_nz_val = w_res;
               end
               8'hC9: begin w_c_n = w_sum[DW];   w_nz_val = w_res;       end
               default: w_set_nz = 1'b0;
            endcase
         end
         StHalt: w_state_n = StHalt;
         default: w_state_n = StFetch;
      endcase
      w_n_n = w_set_nz ? w_nz_val[DW-1]   : r_n;
      w_z_n = w_set_nz ? (w_nz_val == '0) : r_z;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StFetch;
         r_pc    <= RESET_PC;
         r_a     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_ir    <= '0;
         r_n     <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b0;
         r_c     <= 1'b0;
      end else if (RDY) begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_a     <= w_a_n;
         r_x     <= w_x_n;
         r_y     <= w_y_n;
         r_n     <= w_n_n;
         r_v     <= w_v_n;
         r_z     <= w_z_n;
         r_c     <= w_c_n;
         if (r_state == StDecode) r_ir <= D_in[7:0];
      end
   end

   // The zero-page address comes straight from the operand on D_in during EXEC.
   assign w_sta_exec = (r_state == StExec) && (r_ir == 8'h85);
   assign AD         = w_sta_exec ? {{(AW-8){1'b0}}, D_in[7:0]} : r_pc;
   assign RW         = ~w_sta_exec;
   assign D_out      = r_a;
   assign SYNC       = (r_state == StFetch);
   assign HALTED     = (r_state == StHalt);
   assign FLAGS      = {r_n, r_v, r_z, r_c};

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: a table of short programs, each ending in STP, with expected results
// scoreboarded at load time; also hand-written stall, halt, reset and DW=16 sequences.
module tb_core_seq;

   logic        clk = 1'b0;
   logic        rst8, rdy8, ld8;
   logic        rw8, sync8, halt8;
   logic [15:0] ad8;
   logic [7:0]  din8, dout8;
   logic [3:0]  flags8;
   logic [7:0]  mem8 [256];
   logic [7:0]  img8 [256];
   int          wr8;

   logic        rst16, rdy16, ld16;
   logic        rw16, sync16, halt16;
   logic [15:0] ad16, din16, dout16;
   logic [3:0]  flags16;
   logic [15:0] mem16 [256];
   logic [15:0] img16 [256];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   core_seq #(.DW(8), .AW(16), .RESET_PC(16'h0000)) u_dut8 (
      .clk(clk), .rst(rst8), .RDY(rdy8), .RW(rw8), .AD(ad8), .D_in(din8),
      .D_out(dout8), .SYNC(sync8), .HALTED(halt8), .FLAGS(flags8)
   );

   core_seq #(.DW(16), .AW(16), .RESET_PC(16'h0010)) u_dut16 (
      .clk(clk), .rst(rst16), .RDY(rdy16), .RW(rw16), .AD(ad16), .D_in(din16),
      .D_out(dout16), .SYNC(sync16), .HALTED(halt16), .FLAGS(flags16)
   );

   // Synchronous memories: data returned one RDY cycle after the address; held while RDY=0.
   always @(posedge clk) begin
      if (ld8) begin
         for (int i = 0; i < 256; i++) mem8[i] <= img8[i];
         wr8 <= 0;
      end else if (rdy8) begin
         if (!rw8) begin
            mem8[ad8[7:0]] <= dout8;
            wr8 <= wr8 + 1;
         end
         din8 <= mem8[ad8[7:0]];
      end
   end

   always @(posedge clk) begin
      if (ld16) begin
         for (int i = 0; i < 256; i++) mem16[i] <= img16[i];
      end else if (rdy16) begin
         if (!rw16) mem16[ad16[7:0]] <= dout16;
         din16 <= mem16[ad16[7:0]];
      end
   end

   typedef struct {
      string        name;
      logic [127:0] prog;
      int           len;
      logic [7:0]   a;
      logic [3:0]   f;
      int           wr;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [3:0] f;
      logic [15:0] ad;
      int         wr;
   } exp_t;

   vec_t vecs[14];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic load8(input logic [127:0] prog, input int len);
      rst8 = 1'b1;
      for (int i = 0; i < 256; i++) img8[i] = 8'hDB;
      for (int i = 0; i < len; i++) img8[i] = 8'(prog >> (8 * (len - 1 - i)));
      ld8 = 1'b1;
      @(negedge clk);
      ld8 = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_halt8(input string name);
      for (int c = 0; c < 400; c++) begin
         if (halt8) break;
         @(negedge clk);
      end
      check({name, "_halted"}, {31'd0, halt8}, 32'd1);
   endtask

   initial begin
      exp_t e;
      rst8 = 1'b1; rdy8 = 1'b1; ld8 = 1'b0;
      rst16 = 1'b1; rdy16 = 1'b1; ld16 = 1'b0;

      vecs[0]  = '{"lda_adc",  {8'hA9,8'h05,8'h69,8'h03,8'hDB}, 5, 8'h08, 4'b0000, 0};
      vecs[1]  = '{"adc_ovf",  {8'hA9,8'h7F,8'h18,8'h69,8'h01,8'hDB}, 6, 8'h80, 4'b1100, 0};
      vecs[2]  = '{"cmp_eq",   {8'hA9,8'h10,8'hC9,8'h10,8'hDB}, 5, 8'h10, 4'b0011, 0};
      vecs[3]  = '{"cmp_lt",   {8'hA9,8'h10,8'hC9,8'h10,8'hC9,8'h20,8'hDB}, 7, 8'h10, 4'b1000, 0};
      vecs[4]  = '{"dex_inx",  {8'hA2,8'h00,8'hCA,8'hE8,8'h8A,8'hDB}, 6, 8'h00, 4'b0010, 0};
      vecs[5]  = '{"dex_wrap", {8'hA2,8'h00,8'hCA,8'h8A,8'hDB}, 5, 8'hFF, 4'b1000, 0};
      vecs[6]  = '{"sbc",      {8'h38,8'hA9,8'h05,8'hE9,8'h03,8'hDB}, 6, 8'h02, 4'b0001, 0};
      vecs[7]  = '{"logic",    {8'hA9,8'hF0,8'h29,8'h3C,8'h09,8'h01,8'h49,8'hFF,8'hDB}, 9,
                   8'hCE, 4'b1000, 0};
      vecs[8]  = '{"iny_wrap", {8'hA0,8'hFF,8'hC8,8'h98,8'hDB}, 5, 8'h00, 4'b0010, 0};
      vecs[9]  = '{"xfers",    {8'hA9,8'h81,8'hAA,8'hE8,8'h8A,8'hA8,8'h88,8'h98,8'hDB}, 9,
                   8'h81, 4'b1000, 0};
      vecs[10] = '{"adc_carry",{8'h38,8'hA9,8'hFF,8'h69,8'h00,8'hDB}, 6, 8'h00, 4'b0011, 0};
      vecs[11] = '{"undef_nop",{8'hA9,8'h00,8'h02,8'h38,8'hDB}, 5, 8'h00, 4'b0011, 0};
      vecs[12] = '{"sbc_ovf",  {8'h18,8'hA9,8'h80,8'hE9,8'h01,8'hDB}, 6, 8'h7E, 4'b0101, 0};
      vecs[13] = '{"sta",      {8'hA9,8'h5A,8'h85,8'h40,8'hDB}, 5, 8'h5A, 4'b0000, 1};

      repeat (2) @(negedge clk);
      check("rst_ad",    {16'd0, ad8},    32'h0);
      check("rst_rw",    {31'd0, rw8},    32'd1);
      check("rst_sync",  {31'd0, sync8},  32'd1);
      check("rst_halt",  {31'd0, halt8},  32'd0);
      check("rst_dout",  {24'd0, dout8},  32'h0);
      check("rst_flags", {28'd0, flags8}, 32'h0);

      foreach (vecs[k]) begin
         load8(vecs[k].prog, vecs[k].len);
         sb.push_back('{vecs[k].name, vecs[k].a, vecs[k].f, 16'(vecs[k].len), vecs[k].wr});
         rst8 = 1'b0;
         wait_halt8(vecs[k].name);
         e = sb.pop_front();
         check({e.name, "_a"},     {24'd0, dout8},  {24'd0, e.a});
         check({e.name, "_flags"}, {28'd0, flags8}, {28'd0, e.f});
         check({e.name, "_ad"},    {16'd0, ad8},    {16'd0, e.ad});
         check({e.name, "_wr"},    wr8,             e.wr);
      end

      // SYNC marks the two opcode fetches of LDA #; ADC #.
      load8({8'hA9,8'h05,8'h69,8'h03,8'hDB}, 5);
      rst8 = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("sync_c%0d", c), {31'd0, sync8}, (c == 0 || c == 3) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // STA with a three-cycle stall in EXEC.
      load8({8'hA9,8'h5A,8'h85,8'h40,8'hDB}, 5);
      rst8 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (!rw8) break;
         @(negedge clk);
      end
      check("sta_rw_seen", {31'd0, rw8}, 32'd0);
      rdy8 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("stall_ad_%0d", c),   {16'd0, ad8},   32'h0040);
         check($sformatf("stall_rw_%0d", c),   {31'd0, rw8},   32'd0);
         check($sformatf("stall_dout_%0d", c), {24'd0, dout8}, 32'h5A);
         check($sformatf("stall_wr_%0d", c),   wr8,            0);
         @(negedge clk);
      end
      rdy8 = 1'b1;
      wait_halt8("sta_stall");
      check("sta_writes", wr8, 1);
      check("sta_mem40",  {24'd0, mem8[8'h40]}, 32'h5A);

      // HALT ignores RDY and keeps AD fixed.
      for (int c = 0; c < 20; c++) begin
         rdy8 = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("halt_ad",   {16'd0, ad8},   32'h0005);
         check("halt_flag", {31'd0, halt8}, 32'd1);
      end
      rdy8 = 1'b1;

      // Reset in the EXEC cycle of ADC (cycle 5) abandons it.
      load8({8'hA9,8'h05,8'h69,8'h03,8'hDB}, 5);
      rst8 = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_rst_a", {24'd0, dout8}, 32'h05);
      rst8 = 1'b1;
      #1;
      check("mid_rst_ad",    {16'd0, ad8},    32'h0);
      check("mid_rst_a",     {24'd0, dout8},  32'h0);
      check("mid_rst_flags", {28'd0, flags8}, 32'h0);
      check("mid_rst_sync",  {31'd0, sync8},  32'd1);
      @(negedge clk);
      rst8 = 1'b0;
      wait_halt8("rerun");
      check("rerun_a", {24'd0, dout8}, 32'h08);

      // DW=16 overflow from RESET_PC=0x0010.
      for (int i = 0; i < 256; i++) img16[i] = 16'h00DB;
      img16[16] = 16'h00A9; img16[17] = 16'h7FFF; img16[18] = 16'h0069; img16[19] = 16'h0001;
      ld16 = 1'b1;
      @(negedge clk);
      ld16 = 1'b0;
      @(negedge clk);
      check("w16_rst_ad", {16'd0, ad16}, 32'h0010);
      rst16 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (halt16) break;
         @(negedge clk);
      end
      check("w16_halted", {31'd0, halt16},  32'd1);
      check("w16_a",      {16'd0, dout16},  32'h8000);
      check("w16_flags",  {28'd0, flags16}, 32'hC);
      check("w16_ad",     {16'd0, ad16},    32'h0015);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
